tweak_fetch: RTL and testbench

TWEAK_FETCH -- requirements
Module: tweak_fetch

---
 rtl/tweak_pkg.sv | 21 ++
 rtl/tweak_fetch_fifo.sv | 53 +++++
 rtl/tweak_fetch.sv | 96 +++++++++
 tb/tb_tweak_fetch.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tweak_pkg.sv
// Shared fetch-side definitions: word geometry, instruction field positions, fetch FSM states.
package tweak_pkg;

  localparam int WORD_W     = 32;
  localparam int ADDR_W_DEF = 8;

  localparam int ENC_MSB = 31;
  localparam int ENC_LSB = 30;
  localparam int OPC_MSB = 29;
  localparam int OPC_LSB = 24;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } fetch_state_t;

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [WORD_W-1:0] w);
    return w[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/tweak_fetch_fifo.sv
// Prefetch queue: DEPTH-entry circular buffer with push/pop/flush; head visible combinationally.
// Push while full and pop while empty are ignored; head reads as zero when empty.
module tweak_fetch_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push  = push && (count != FULL) && !flush;
  assign do_pop   = pop && (count != '0) && !flush;
  assign head_dat = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tweak_fetch.sv
// Instruction prefetcher: credit-limited sequential reads into a queue; ins_valid = memory latency + 1.
// Decoder stalls hold the head; redirect flushes the queue and drains in-flight responses before refetching.
module tweak_fetch
  import tweak_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              ins_valid,
  output logic [WORD_W-1:0] ins_data,
  output logic [ADDR_W-1:0] ins_pc,
  input  logic              ins_ready
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = WORD_W + ADDR_W;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  out_next;
  logic [CNT_W-1:0]  fifo_count;
  logic              rsp_ok;
  logic              credit;
  logic              issue;
  logic              push;
  logic              pop;
  logic [ENT_W-1:0]  push_dat;
  logic [ENT_W-1:0]  head_dat;

  // Queue slots plus in-flight reads never exceed DEPTH, so every response has a slot.
  assign rsp_ok = mem_rvalid && (outstanding != '0);
  assign credit = ({1'b0, fifo_count} + {1'b0, outstanding}) < DEPTH_C;
  assign issue  = !RESET && !redirect && (state == ST_RUN) && credit;
  assign push   = !redirect && (state == ST_RUN) && rsp_ok;
  assign pop    = ins_valid && ins_ready && !redirect;

  // In RUN, in-flight reads are the consecutive addresses just below pc, oldest first.
  assign push_dat = {mem_rdata, pc - ADDR_W'(outstanding)};

  assign mem_req   = issue;
  assign mem_addr  = pc;
  assign ins_valid = (fifo_count != '0);
  assign {ins_data, ins_pc} = head_dat;

  always_comb begin
    out_next = outstanding;
    if (issue && !rsp_ok) begin
      out_next = outstanding + 1'b1;
    end else if (!issue && rsp_ok) begin
      out_next = outstanding - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= ST_RUN;
      pc          <= '0;
      outstanding <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect) begin
        pc    <= redirect_addr;
        state <= (out_next != '0) ? ST_DRAIN : ST_RUN;
      end else begin
        if (issue) pc <= pc + 1'b1;
        if ((state == ST_DRAIN) && (out_next == '0)) state <= ST_RUN;
      end
    end
  end

  tweak_fetch_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .CLK      (CLK),
    .RESET    (RESET),
    .flush    (redirect),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_tweak_fetch.sv
// Bench for tweak_fetch: in-order memory model with configurable latency and a sequential-stream reference.
module tb_tweak_fetch;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_addr = '0;
  logic              ins_valid;
  logic [31:0]       ins_data;
  logic [ADDR_W-1:0] ins_pc;
  logic              ins_ready = 1'b0;

  int checks = 0;
  int errors = 0;
  int lat_base = 1;
  int lat_jit = 0;
  bit spurious = 1'b0;
  int cyc = 0;

  tweak_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .mem_req       (mem_req),
    .mem_addr      (mem_addr),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .redirect      (redirect),
    .redirect_addr (redirect_addr),
    .ins_valid     (ins_valid),
    .ins_data      (ins_data),
    .ins_pc        (ins_pc),
    .ins_ready     (ins_ready)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] word_of(input logic [7:0] a);
    return {a ^ 8'hA5, a, 8'h3C, ~a};
  endfunction

  // Instruction memory: in-order, one response per cycle, latency lat_base..lat_base+lat_jit.
  typedef struct {
    int         due;
    logic [7:0] addr;
  } rq_t;

  initial begin
    rq_t        q[$];
    rq_t        e;
    bit         deliv;
    logic       r;
    logic [7:0] a;
    logic       rst;
    deliv      = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge CLK);
      r   = mem_req;
      a   = mem_addr;
      rst = RESET;
      @(posedge CLK);
      #2;
      cyc++;
      if (rst) begin
        q.delete();
      end else begin
        if (deliv) void'(q.pop_front());
        if (r) begin
          e.due  = cyc - 1 + lat_base + $urandom_range(0, lat_jit);
          e.addr = a;
          q.push_back(e);
        end
      end
      deliv      = (q.size() > 0) && (q[0].due <= cyc);
      mem_rvalid = deliv || spurious;
      mem_rdata  = deliv ? word_of(q[0].addr) : $urandom;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET    = 1'b1;
    redirect = 1'b0;
    cycle();
    cycle();
    RESET = 1'b0;
  endtask

  task automatic test_reset();
    RESET     = 1'b1;
    redirect  = 1'b0;
    ins_ready = 1'b1;
    lat_base  = 1;
    cycle(); cycle(); cycle();
    @(negedge CLK);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL reset_ins_valid: got %b want 0", ins_valid); end
    checks++; if (ins_data !== 32'h0) begin errors++; $display("FAIL reset_ins_data: got %h want 0", ins_data); end
    checks++; if (ins_pc !== 8'h0) begin errors++; $display("FAIL reset_ins_pc: got %h want 0", ins_pc); end
    cycle();
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
      errors++; $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=00", mem_req, mem_addr);
    end
    cycle();
  endtask

  task automatic test_stream();
    do_reset();
    ins_ready = 1'b1;
    lat_base  = 1;
    for (int rel = 0; rel < 12; rel++) begin
      @(negedge CLK);
      checks++;
      if (mem_req !== 1'b1 || mem_addr !== 8'(rel)) begin
        errors++; $display("FAIL stream_req cycle %0d: got req=%b addr=%h want req=1 addr=%h", rel, mem_req, mem_addr, 8'(rel));
      end
      checks++;
      if (ins_valid !== (rel >= 2)) begin
        errors++; $display("FAIL stream_valid cycle %0d: got %b want %b", rel, ins_valid, (rel >= 2));
      end
      if (rel >= 2) begin
        checks++;
        if (ins_pc !== 8'(rel - 2) || ins_data !== word_of(8'(rel - 2))) begin
          errors++; $display("FAIL stream_ins cycle %0d: got pc=%h data=%h want pc=%h data=%h", rel, ins_pc, ins_data, 8'(rel - 2), word_of(8'(rel - 2)));
        end
      end
      cycle();
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    int exp;
    do_reset();
    ins_ready = 1'b0;
    lat_base  = 1;
    nreq      = 0;
    for (int rel = 0; rel < 12; rel++) begin
      spurious = (rel == 8);
      @(negedge CLK);
      if (mem_req === 1'b1) begin
        checks++;
        if (mem_addr !== 8'(nreq)) begin
          errors++; $display("FAIL bp_req_addr: got %h want %h", mem_addr, 8'(nreq));
        end
        nreq++;
      end
      if (rel >= 2) begin
        checks++;
        if (ins_valid !== 1'b1 || ins_pc !== 8'h00 || ins_data !== word_of(8'h00)) begin
          errors++; $display("FAIL bp_hold cycle %0d: got valid=%b pc=%h data=%h want 1/00/%h", rel, ins_valid, ins_pc, ins_data, word_of(8'h00));
        end
      end
      cycle();
    end
    spurious = 1'b0;
    checks++; if (nreq != DEPTH) begin errors++; $display("FAIL bp_req_count: got %0d want %0d", nreq, DEPTH); end
    @(negedge CLK);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL bp_req_low: got %b want 0", mem_req); end
    cycle();
    ins_ready = 1'b1;
    exp = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (ins_valid === 1'b1) begin
        checks++;
        if (ins_pc !== 8'(exp) || ins_data !== word_of(8'(exp))) begin
          errors++; $display("FAIL bp_release: got pc=%h data=%h want pc=%h data=%h", ins_pc, ins_data, 8'(exp), word_of(8'(exp)));
        end
        exp++;
      end
      cycle();
    end
    checks++; if (exp < 10) begin errors++; $display("FAIL bp_progress: got %0d instructions want at least 10", exp); end
  endtask

  task automatic test_redirect_drain();
    int  disc;
    int  exp;
    bit  found;
    do_reset();
    ins_ready = 1'b1;
    lat_base  = 3;
    cycle(); cycle(); cycle();
    redirect      = 1'b1;
    redirect_addr = 8'h40;
    @(negedge CLK);
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL drain_no_issue: got %b want 0", mem_req); end
    disc = (mem_rvalid === 1'b1) ? 1 : 0;
    cycle();
    redirect = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge CLK);
      if (mem_req === 1'b1) begin
        found = 1'b1;
      end else begin
        if (mem_rvalid === 1'b1) disc++;
        checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL drain_ins_valid: got %b want 0", ins_valid); end
        cycle();
      end
    end
    checks++;
    if (!found || mem_addr !== 8'h40) begin
      errors++; $display("FAIL drain_restart: got found=%b addr=%h want found=1 addr=40", found, mem_addr);
    end
    checks++; if (disc != 3) begin errors++; $display("FAIL drain_discards: got %0d want 3", disc); end
    cycle();
    exp = 'h40;
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      if (ins_valid === 1'b1) begin
        checks++;
        if (ins_pc !== 8'(exp) || ins_data !== word_of(8'(exp))) begin
          errors++; $display("FAIL drain_stream: got pc=%h data=%h want pc=%h", ins_pc, ins_data, 8'(exp));
        end
        exp++;
      end
      cycle();
    end
    checks++; if (exp < 'h44) begin errors++; $display("FAIL drain_progress: got next pc %h want at least 44", exp); end
  endtask

  task automatic test_collision();
    logic [7:0] target;
    logic [7:0] exp;
    int         seen;
    do_reset();
    ins_ready = 1'b1;
    lat_base  = 1;
    repeat (6) cycle();
    target        = 8'($urandom_range(128, 239));
    redirect      = 1'b1;
    redirect_addr = target;
    @(negedge CLK);
    checks++;
    if (ins_valid !== 1'b1 || mem_rvalid !== 1'b1) begin
      errors++; $display("FAIL collide_pre: got valid=%b rvalid=%b want 1/1", ins_valid, mem_rvalid);
    end
    cycle();
    redirect = 1'b0;
    @(negedge CLK);
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL collide_flush: got %b want 0", ins_valid); end
    cycle();
    exp  = target;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge CLK);
      if (ins_valid === 1'b1) begin
        checks++;
        if (ins_pc !== exp || ins_data !== word_of(exp)) begin
          errors++; $display("FAIL collide_stream: got pc=%h data=%h want pc=%h", ins_pc, ins_data, exp);
        end
        exp++;
        seen++;
      end
      cycle();
    end
    checks++; if (seen < 5) begin errors++; $display("FAIL collide_progress: got %0d want at least 5", seen); end
  endtask

  task automatic test_wrap();
    logic [7:0] reqs[$];
    logic [7:0] pcs[$];
    logic [7:0] wexp[4];
    wexp          = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    ins_ready     = 1'b1;
    lat_base      = 1;
    redirect      = 1'b1;
    redirect_addr = 8'hFE;
    @(negedge CLK);
    cycle();
    redirect = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (mem_req === 1'b1 && reqs.size() < 4) reqs.push_back(mem_addr);
      if (ins_valid === 1'b1 && pcs.size() < 4) pcs.push_back(ins_pc);
      cycle();
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (reqs.size() <= k || reqs[k] !== wexp[k]) begin
        errors++; $display("FAIL wrap_req[%0d]: got %h want %h", k, (reqs.size() > k) ? reqs[k] : 8'hxx, wexp[k]);
      end
      checks++;
      if (pcs.size() <= k || pcs[k] !== wexp[k]) begin
        errors++; $display("FAIL wrap_pc[%0d]: got %h want %h", k, (pcs.size() > k) ? pcs[k] : 8'hxx, wexp[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int exp;
    do_reset();
    ins_ready = 1'b1;
    lat_base  = 3;
    cycle(); cycle();
    RESET = 1'b1;
    @(negedge CLK);
    cycle();
    @(negedge CLK);
    checks++;
    if (ins_valid !== 1'b0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL midreset_quiet: got valid=%b req=%b want 0/0", ins_valid, mem_req);
    end
    cycle();
    RESET = 1'b0;
    @(negedge CLK);
    checks++;
    if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
      errors++; $display("FAIL midreset_restart: got req=%b addr=%h want 1/00", mem_req, mem_addr);
    end
    cycle();
    exp = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      if (ins_valid === 1'b1) begin
        checks++;
        if (ins_pc !== 8'(exp) || ins_data !== word_of(8'(exp))) begin
          errors++; $display("FAIL midreset_stream: got pc=%h data=%h want pc=%h", ins_pc, ins_data, 8'(exp));
        end
        exp++;
      end
      cycle();
    end
    checks++; if (exp < 6) begin errors++; $display("FAIL midreset_progress: got %0d want at least 6", exp); end
  endtask

  // Reference: requests and delivered instructions are each a consecutive address run
  // starting at the last redirect target, and issued-minus-consumed never exceeds DEPTH.
  task automatic test_random();
    logic [7:0] exp_req;
    logic [7:0] exp_ins;
    int         issued;
    int         consumed;
    int         total;
    do_reset();
    lat_base = 1;
    lat_jit  = 2;
    exp_req  = 8'h00;
    exp_ins  = 8'h00;
    issued   = 0;
    consumed = 0;
    total    = 0;
    for (int i = 0; i < 600; i++) begin
      ins_ready     = ($urandom_range(0, 3) != 0);
      redirect      = ($urandom_range(0, 24) == 0);
      redirect_addr = 8'($urandom);
      @(negedge CLK);
      if (redirect) begin
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rand_redirect_req: got %b want 0", mem_req); end
        exp_req  = redirect_addr;
        exp_ins  = redirect_addr;
        issued   = 0;
        consumed = 0;
      end else begin
        if (mem_req === 1'b1) begin
          checks++;
          if (mem_addr !== exp_req) begin
            errors++; $display("FAIL rand_req_addr: got %h want %h", mem_addr, exp_req);
          end
          exp_req++;
          issued++;
          checks++;
          if (issued - consumed > DEPTH) begin
            errors++; $display("FAIL rand_credit: got %0d in use want at most %0d", issued - consumed, DEPTH);
          end
        end
        if (ins_valid === 1'b1 && ins_ready) begin
          checks++;
          if (ins_pc !== exp_ins || ins_data !== word_of(exp_ins)) begin
            errors++; $display("FAIL rand_ins: got pc=%h data=%h want pc=%h data=%h", ins_pc, ins_data, exp_ins, word_of(exp_ins));
          end
          exp_ins++;
          consumed++;
          total++;
        end
      end
      cycle();
    end
    redirect = 1'b0;
    lat_jit  = 0;
    checks++; if (total < 150) begin errors++; $display("FAIL rand_progress: got %0d instructions want at least 150", total); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drain();
    test_collision();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
